dif_butterfly: RTL and testbench
================================

DIF_BUTTERFLY -- requirements
Module: dif_butterfly

Interface
REQ-001 Parameter WIDTH, default 32, word width of all data, twiddle and modulus ports.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  qualifies A, B, W, mode and halve in the current cycle.
REQ-005 mode  input  1  selects the operation: 0 = Gentleman-Sande butterfly, 1 = multiply A by W.
REQ-006 halve  input  1  when 1, both results are scaled by 2^-1 mod modulus (INTT final-stage scaling).
REQ-007 A  input  WIDTH  first operand, in the range 0 to modulus-1.
REQ-008 B  input  WIDTH  second operand, in the range 0 to modulus-1; ignored when mode=1.
REQ-009 W  input  WIDTH  twiddle factor, in the range 0 to modulus-1.
REQ-010 modulus  input  WIDTH  odd modulus q, with q < 2^(WIDTH-1); held static during operation.
REQ-011 out_valid  output  1  qualifies A_out and B_out.
REQ-012 A_out  output  WIDTH  sum result.
REQ-013 B_out  output  WIDTH  product result.

Function
REQ-014 Mode 0 results: A_out = (A+B) mod q and B_out = ((A-B) mod q)*W mod q, each multiplied by 2^-1 mod q when halve=1.
REQ-015 Mode 1 results: A_out = 0 and B_out = A*W mod q (times 2^-1 mod q when halve=1).
REQ-016 S1 registers the sum and difference: sum = A+B, minus q if A+B >= q; diff = A-B, plus q if A-B < 0; uses WIDTH+1-bit intermediates.
REQ-017 S2 halves when halve=1: an even x becomes x>>1; an odd x becomes (x+q)>>1 using WIDTH+1 bits; the result is always < q.
REQ-018 S2 feeds the halved diff and W (delayed 2 cycles) to one ModMult instance of latency `INTMUL_DELAY+`MODRED_DELAY.
REQ-019 A delay line of matching length carries the S2 sum.
REQ-020 The output stage registers A_out and B_out.
REQ-021 Total latency is LAT = `INTMUL_DELAY + `MODRED_DELAY + 3 cycles: an input accepted in cycle t appears with out_valid=1 in cycle t+LAT.
REQ-022 in_valid propagates through a LAT-deep valid shift register; throughput is one operation per cycle, with no backpressure and no stalls.
REQ-023 A_out and B_out load only when the final-stage valid bit is 1; otherwise they hold their last value.
REQ-024 Gaps in in_valid produce identical gaps in out_valid.
REQ-025 Back-to-back inputs produce back-to-back outputs with no reordering.
REQ-026 mode and halve are sampled per operation and travel with that operation's data.
REQ-027 Changing mode or halve between consecutive operations produces no corruption.
REQ-028 Operands that are out of range (>= q) produce undefined results, and out_valid timing is still honoured.

Reset
REQ-029 While reset_n=0, out_valid, A_out, B_out, all valid bits and the sum delay line SHALL be 0 immediately, without waiting for a clock edge.
REQ-030 ModMult SHALL receive reset = ~reset_n; its stale contents are masked by the cleared valid pipeline.
REQ-031 Operations in flight when reset asserts SHALL be discarded, and no out_valid pulse SHALL occur for them after release.
REQ-032 The first in_valid sampled at the first rising edge after release SHALL appear LAT cycles later.

Structure
REQ-033 LAT and the delay macros SHALL come from defines.v (INTMUL_DELAY, MODRED_DELAY).
REQ-034 A shared package or header SHALL hold the LAT localparam formula so that pipeline-aligned stages can reuse it.
REQ-035 There SHALL be exactly one sub-module, ModMult.
REQ-036 The modular add/sub and halving logic SHALL be inline; the delay lines SHALL be local register arrays.

Verification (q=17)
REQ-037 A=5, B=3, W=2, mode=0, halve=0 -> after LAT cycles A_out=8, B_out=4, and out_valid is high for exactly 1 cycle.
REQ-038 Wrap-around case: A=3, B=5, W=2 -> A_out=8, B_out=13; and A=16, B=16, W=1 -> A_out=15, B_out=0.
REQ-039 Halving case: A=16, B=16, W=1, halve=1 -> A_out=16, B_out=0; and A=5, B=3, W=2, halve=1 -> A_out=4, B_out=2.
REQ-040 Mode 1 case: A=5, B=9, W=3, mode=1 -> A_out=0, B_out=15; with halve=1 -> B_out=16.
REQ-041 Streaming case: 20 back-to-back random valid operations followed by a 3-cycle gap -> outputs match a reference model in order, and the out_valid pattern is the in_valid pattern delayed by LAT.
REQ-042 Reset mid-stream: assert reset_n=0 for 1 cycle while 4 operations are in flight -> outputs are 0 immediately, no out_valid for the flushed operations, and an operation issued after release emerges at LAT.

Source files
------------

// File: rtl/dif_butterfly_pkg.sv
// Shared pipeline constants for the DIF butterfly.
// INTMUL_DELAY / MODRED_DELAY are the project-wide ModMult stage counts
// (the defines.v values). A definition made on the tool command line wins.
`ifndef INTMUL_DELAY
`define INTMUL_DELAY 2
`endif
`ifndef MODRED_DELAY
`define MODRED_DELAY 2
`endif

package dif_butterfly_pkg;

  // ModMult latency: integer multiply stages followed by reduction stages.
  localparam int MM_LAT = `INTMUL_DELAY + `MODRED_DELAY;

  // End-to-end latency: S1 (add/sub), S2 (halve), ModMult, output register.
  localparam int LAT = MM_LAT + 3;

  // Operation select carried on the mode input.
  typedef enum logic {
    MODE_GS  = 1'b0,  // Gentleman-Sande butterfly
    MODE_MUL = 1'b1   // plain A*W modular multiply
  } bfly_mode_e;

endpackage

// File: rtl/dif_butterfly_modmult.sv
// Pipelined modular multiplier: o_c = (i_a * i_b) mod i_q.
// Latency is INTMUL_DELAY + MODRED_DELAY cycles, one result per cycle.
// The reduction assumes i_q is held static while operands are in flight.
module ModMult #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_q,
  output logic [WIDTH-1:0] o_c
);

  localparam int MUL_D = `INTMUL_DELAY;
  localparam int RED_D = `MODRED_DELAY;

  logic [2*WIDTH-1:0] r_prod [MUL_D];
  logic [WIDTH-1:0]   r_red  [RED_D];
  logic [2*WIDTH-1:0] w_q_ext;
  logic [WIDTH-1:0]   w_rem;

  assign w_q_ext = {{WIDTH{1'b0}}, i_q};

  // A zero modulus only occurs before configuration; force a defined value.
  assign w_rem = (i_q == '0) ? '0 : WIDTH'(r_prod[MUL_D-1] % w_q_ext);

  // Full-width integer product, then plain delay to balance the multiplier.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < MUL_D; i++) r_prod[i] <= '0;
    end else begin
      r_prod[0] <= {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
      for (int i = 1; i < MUL_D; i++) r_prod[i] <= r_prod[i-1];
    end
  end

  // Reduce the product modulo q, then delay to the full reduction latency.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < RED_D; i++) r_red[i] <= '0;
    end else begin
      r_red[0] <= w_rem;
      for (int i = 1; i < RED_D; i++) r_red[i] <= r_red[i-1];
    end
  end

  assign o_c = r_red[RED_D-1];

endmodule

// File: rtl/dif_butterfly.sv
// Gentleman-Sande (DIF) NTT butterfly with optional INTT 1/2 scaling.
//   mode 0: A_out = (A+B) mod q,  B_out = ((A-B) mod q) * W mod q
//   mode 1: A_out = 0,            B_out = A * W mod q
//   halve=1 multiplies both results by 2^-1 mod q.
// Handshake: in_valid qualifies A/B/W/mode/halve in the cycle it is high and
// is always accepted (no ready, no stalls); out_valid pulses exactly LAT
// cycles later for that operation, in issue order, and A_out/B_out hold
// their last value while out_valid is low.
module dif_butterfly
  import dif_butterfly_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             mode,
  input  logic             halve,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] W,
  input  logic [WIDTH-1:0] modulus,
  output logic             out_valid,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out
);

  // ---------------- S1: modular add / subtract ----------------
  logic [WIDTH:0]   w_sum_raw;
  logic [WIDTH:0]   w_diff_raw;
  logic [WIDTH-1:0] w_sum_mod;
  logic [WIDTH-1:0] w_diff_mod;
  logic [WIDTH-1:0] w_s1_sum;
  logic [WIDTH-1:0] w_s1_diff;
  logic             w_is_mul;

  assign w_sum_raw  = {1'b0, A} + {1'b0, B};
  assign w_diff_raw = {1'b0, A} - {1'b0, B};
  assign w_sum_mod  = (w_sum_raw >= {1'b0, modulus}) ?
                      WIDTH'(w_sum_raw - {1'b0, modulus}) : w_sum_raw[WIDTH-1:0];
  // The top bit of the WIDTH+1 difference is the borrow (A < B).
  assign w_diff_mod = w_diff_raw[WIDTH] ?
                      WIDTH'(w_diff_raw + {1'b0, modulus}) : w_diff_raw[WIDTH-1:0];

  // Multiply mode routes A into the multiplier path and zeroes the sum path.
  assign w_is_mul  = (bfly_mode_e'(mode) == MODE_MUL);
  assign w_s1_sum  = w_is_mul ? '0 : w_sum_mod;
  assign w_s1_diff = w_is_mul ? A  : w_diff_mod;

  logic [WIDTH-1:0] r_s1_sum;
  logic [WIDTH-1:0] r_s1_diff;
  logic [WIDTH-1:0] r_s1_w;
  logic             r_s1_halve;

  // S1 register: sum, difference, twiddle and the per-op halve flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_sum   <= '0;
      r_s1_diff  <= '0;
      r_s1_w     <= '0;
      r_s1_halve <= 1'b0;
    end else begin
      r_s1_sum   <= w_s1_sum;
      r_s1_diff  <= w_s1_diff;
      r_s1_w     <= W;
      r_s1_halve <= halve;
    end
  end

  // ---------------- S2: optional halving mod q ----------------
  // Odd x: (x+q) is even and < 2q, so (x+q)>>1 < q is x * 2^-1 mod q.
  logic [WIDTH:0]   w_sum_odd;
  logic [WIDTH:0]   w_diff_odd;
  logic [WIDTH-1:0] w_sum_half;
  logic [WIDTH-1:0] w_diff_half;
  logic [WIDTH-1:0] w_s2_sum;
  logic [WIDTH-1:0] w_s2_diff;

  assign w_sum_odd   = {1'b0, r_s1_sum}  + {1'b0, modulus};
  assign w_diff_odd  = {1'b0, r_s1_diff} + {1'b0, modulus};
  assign w_sum_half  = r_s1_sum[0]  ? WIDTH'(w_sum_odd >> 1)  : (r_s1_sum >> 1);
  assign w_diff_half = r_s1_diff[0] ? WIDTH'(w_diff_odd >> 1) : (r_s1_diff >> 1);
  assign w_s2_sum    = r_s1_halve ? w_sum_half  : r_s1_sum;
  assign w_s2_diff   = r_s1_halve ? w_diff_half : r_s1_diff;

  logic [WIDTH-1:0] r_s2_sum;
  logic [WIDTH-1:0] r_s2_diff;
  logic [WIDTH-1:0] r_s2_w;

  // S2 register: scaled sum/diff and the twiddle, now two cycles old.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_sum  <= '0;
      r_s2_diff <= '0;
      r_s2_w    <= '0;
    end else begin
      r_s2_sum  <= w_s2_sum;
      r_s2_diff <= w_s2_diff;
      r_s2_w    <= r_s1_w;
    end
  end

  // ---------------- Modular multiply ----------------
  logic             w_mm_rst;
  logic [WIDTH-1:0] w_mm_out;

  assign w_mm_rst = ~reset_n;

  ModMult #(.WIDTH(WIDTH)) u_modmult (
    .clk   (clk),
    .i_rst (w_mm_rst),
    .i_a   (r_s2_diff),
    .i_b   (r_s2_w),
    .i_q   (modulus),
    .o_c   (w_mm_out)
  );

  // Sum delay line matching the multiplier latency.
  logic [WIDTH-1:0] r_sum_dly [MM_LAT];

  // Carry the S2 sum alongside the product.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MM_LAT; i++) r_sum_dly[i] <= '0;
    end else begin
      r_sum_dly[0] <= r_s2_sum;
      for (int i = 1; i < MM_LAT; i++) r_sum_dly[i] <= r_sum_dly[i-1];
    end
  end

  // ---------------- Valid pipeline and output stage ----------------
  // Bit k is high in the cycle the operation sits k+1 stages deep; the top
  // bit is out_valid. Clearing it on reset discards in-flight operations.
  logic [LAT-1:0] r_vld;

  // Shift in_valid down the full latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_vld <= '0;
    else          r_vld <= {r_vld[LAT-2:0], in_valid};
  end

  assign out_valid = r_vld[LAT-1];

  // Load results only for a valid operation leaving the multiplier.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      A_out <= '0;
      B_out <= '0;
    end else if (r_vld[LAT-2]) begin
      A_out <= r_sum_dly[MM_LAT-1];
      B_out <= w_mm_out;
    end
  end

endmodule

// File: tb/tb_dif_butterfly.sv
// Self-checking bench for dif_butterfly: directed vector table, random
// streaming against a plain-arithmetic reference model, reset corner cases.
module tb_dif_butterfly;
  import dif_butterfly_pkg::*;

  localparam int WIDTH = 32;
  localparam longint unsigned Q_SMALL = 64'd17;
  localparam longint unsigned Q_BIG   = 64'd2147483629;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             mode;
  logic             halve;
  logic [WIDTH-1:0] A, B, W, modulus;
  logic             out_valid;
  logic [WIDTH-1:0] A_out, B_out;

  always #5 clk = ~clk;

  dif_butterfly #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .mode      (mode),
    .halve     (halve),
    .A         (A),
    .B         (B),
    .W         (W),
    .modulus   (modulus),
    .out_valid (out_valid),
    .A_out     (A_out),
    .B_out     (B_out)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- scoreboard ----------------
  logic [2*WIDTH-1:0] exp_q[$];   // {A_out, B_out} expected, issue order
  int                 due_q[$];   // cycle in which out_valid must be seen
  logic [WIDTH-1:0]   last_a = '0;
  logic [WIDTH-1:0]   last_b = '0;

  // Reference: results from the modular-arithmetic definition.
  function automatic logic [2*WIDTH-1:0] ref_bfly(input longint unsigned a, b, w, q,
                                                  input bit m, h);
    longint unsigned s, d, sc;
    sc = h ? (q + 1) / 2 : 1;
    if (m) begin
      s = 0;
      d = a;
    end else begin
      s = (a + b) % q;
      d = (a + q - b) % q;
    end
    s = (s * sc) % q;
    d = (d * w) % q;
    d = (d * sc) % q;
    return {s[WIDTH-1:0], d[WIDTH-1:0]};
  endfunction

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [2*WIDTH-1:0] e;
    int d;
    if (!reset_n) begin
      n_tests++;
      if (out_valid !== 1'b0 || A_out !== '0 || B_out !== '0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got v=%b A=%0d B=%0d required 0 0 0",
                 cyc, out_valid, A_out, B_out);
      end
      last_a = '0;
      last_b = '0;
    end else if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid cyc=%0d got A=%0d B=%0d required no output",
                 cyc, A_out, B_out);
      end else begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        n_tests++;
        if (d != cyc) begin
          n_fail++;
          $display("FAIL valid_timing got cycle %0d required cycle %0d", cyc, d);
        end
        n_tests++;
        if ({A_out, B_out} !== e) begin
          n_fail++;
          $display("FAIL data cyc=%0d got A=%0d B=%0d required A=%0d B=%0d",
                   cyc, A_out, B_out, e[2*WIDTH-1:WIDTH], e[WIDTH-1:0]);
        end
        last_a = e[2*WIDTH-1:WIDTH];
        last_b = e[WIDTH-1:0];
      end
    end else begin
      n_tests++;
      if (A_out !== last_a || B_out !== last_b) begin
        n_fail++;
        $display("FAIL output_hold cyc=%0d got A=%0d B=%0d required A=%0d B=%0d",
                 cyc, A_out, B_out, last_a, last_b);
      end
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missing_valid cyc=%0d got out_valid=0 required 1 (due %0d)",
                 cyc, due_q[0]);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [WIDTH-1:0] a, b, w, input logic m, h,
                       input logic [WIDTH-1:0] ea, eb);
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    A = a; B = b; W = w; mode = m; halve = h;
    exp_q.push_back({ea, eb});
    due_q.push_back(cyc + LAT);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      in_valid = 1'b0;
      A = $urandom; B = $urandom; W = $urandom;
      mode = 1'($urandom_range(0, 1));
      halve = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic issue_rand(input longint unsigned q);
    logic [WIDTH-1:0]   a, b, w;
    logic               m, h;
    logic [2*WIDTH-1:0] r;
    a = $urandom_range(0, 32'(q - 1));
    b = $urandom_range(0, 32'(q - 1));
    w = $urandom_range(0, 32'(q - 1));
    if ($urandom_range(0, 5) == 0) a = 32'(q - 1);
    if ($urandom_range(0, 5) == 0) b = 32'(q - 1);
    m = 1'($urandom_range(0, 1));
    h = 1'($urandom_range(0, 1));
    r = ref_bfly(a, b, w, q, m, h);
    issue(a, b, w, m, h, r[2*WIDTH-1:WIDTH], r[WIDTH-1:0]);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (due_q.size() > 0 && t < LAT + 20) begin
      @(negedge clk);
      #2;
      t++;
    end
    n_tests++;
    if (due_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout got %0d pending required 0", due_q.size());
      exp_q.delete();
      due_q.delete();
    end
  endtask

  // ---------------- directed vectors (q = 17) ----------------
  typedef struct {
    logic [WIDTH-1:0] a, b, w;
    logic             m, h;
    logic [WIDTH-1:0] ea, eb;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got no finish required finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{a:5,  b:3,  w:2, m:0, h:0, ea:8,  eb:4};
    vecs[1] = '{a:3,  b:5,  w:2, m:0, h:0, ea:8,  eb:13};
    vecs[2] = '{a:16, b:16, w:1, m:0, h:0, ea:15, eb:0};
    vecs[3] = '{a:16, b:16, w:1, m:0, h:1, ea:16, eb:0};
    vecs[4] = '{a:5,  b:3,  w:2, m:0, h:1, ea:4,  eb:2};
    vecs[5] = '{a:5,  b:9,  w:3, m:1, h:0, ea:0,  eb:15};
    vecs[6] = '{a:5,  b:9,  w:3, m:1, h:1, ea:0,  eb:16};

    // Power-on reset: outputs must be zero before any clock edge.
    reset_n = 1'b0; in_valid = 1'b0; mode = 1'b0; halve = 1'b0;
    A = '0; B = '0; W = '0; modulus = 32'(Q_SMALL);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || A_out !== '0 || B_out !== '0) begin
      n_fail++;
      $display("FAIL por_state got v=%b A=%0d B=%0d required 0 0 0", out_valid, A_out, B_out);
    end
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    idle(2);

    // Isolated directed vectors: each must pulse out_valid exactly once.
    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].w, vecs[i].m, vecs[i].h, vecs[i].ea, vecs[i].eb);
      idle(LAT + 2);
    end
    drain();

    // Directed vectors back to back.
    for (int i = 0; i < 7; i++)
      issue(vecs[i].a, vecs[i].b, vecs[i].w, vecs[i].m, vecs[i].h, vecs[i].ea, vecs[i].eb);
    idle(2);
    drain();

    // 20 back-to-back random operations then a 3-cycle gap, twice.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 20; i++) issue_rand(Q_SMALL);
      idle(3);
    end
    drain();

    // Mixed gaps, per-op mode/halve changes.
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      else issue_rand(Q_SMALL);
    end
    idle(1);
    drain();

    // Reset with 4 operations in flight.
    for (int i = 0; i < 4; i++) issue_rand(Q_SMALL);
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    reset_n  = 1'b0;
    exp_q.delete();
    due_q.delete();
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || A_out !== '0 || B_out !== '0) begin
      n_fail++;
      $display("FAIL async_reset got v=%b A=%0d B=%0d required 0 0 0", out_valid, A_out, B_out);
    end
    @(negedge clk);
    #1;
    // Release with an operation presented for the very first edge.
    reset_n = 1'b1;
    in_valid = 1'b1; A = 5; B = 3; W = 2; mode = 1'b0; halve = 1'b0;
    exp_q.push_back({32'd8, 32'd4});
    due_q.push_back(cyc + LAT);
    idle(LAT + 3);
    drain();

    // Large modulus, changed only while the pipeline is idle.
    modulus = 32'(Q_BIG);
    idle(LAT + 1);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      else issue_rand(Q_BIG);
    end
    idle(1);
    drain();
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
